// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus of the sequential divider
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    modport master(output start, op, dividend, divisor, input busy, done, result);
    modport slave(input start, op, dividend, divisor, output busy, done, result);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M DIV/DIVU/REM/REMU by restoring division, one quotient bit per cycle
module seq_divider #(parameter int WIDTH = 32) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    logic             rsel_q, rsel_d, qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, done_q, done_d;
    logic [WIDTH:0]   trial;
    logic             sgn;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            rsel_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            rsel_q  <= rsel_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end
    // quo_q starts as the dividend magnitude and shifts its bits into the remainder as quotient bits fill in
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        rsel_d  = rsel_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        sgn     = ~bus.op[0];
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                cnt_d   = '0;
                rem_d   = '0;
                rsel_d  = bus.op[1];
                quo_d   = (sgn && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                dvs_d   = (sgn && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
                qneg_d  = sgn && (bus.dividend[WIDTH-1] != bus.divisor[WIDTH-1]);
                rneg_d  = sgn && bus.dividend[WIDTH-1];
                zero_d  = bus.divisor == '0;
            end
            RUN: begin
                rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                // divide-by-zero leaves rem = dividend magnitude, so only the quotient needs overriding
                state_d = IDLE;
                done_d  = 1'b1;
                res_d   = rsel_q ? (rneg_q ? -rem_q : rem_q) :
                          zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy   = state_q != IDLE;
    assign bus.done   = done_q;
    assign bus.result = res_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors plus handshake and reset sequences for seq_divider
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    seq_divider_if #(.WIDTH(32)) bus();
    seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[16];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op = op;
        bus.dividend = a;
        bus.divisor = b;
        step();
        bus.start = 1'b0;
        bus.op = ~op;
        bus.dividend = 32'h5a5a_1234;
        bus.divisor = 32'h0000_0003;
    endtask
    task automatic wait_done(input string name, input int n0, output int lat);
        int n = n0;
        logic busy_gap = 1'b0;
        while (!bus.done && n < 100) begin
            if (!bus.busy) busy_gap = 1'b1;
            step();
            n++;
        end
        lat = n;
        chk({name, "_busy_gap"}, {31'd0, busy_gap}, 32'd0);
    endtask
    task automatic run_vec(input vec_t v);
        int lat;
        launch(v.op, v.a, v.b);
        wait_done(v.name, 1, lat);
        chk({v.name, "_latency"}, lat, 34);
        chk({v.name, "_result"}, bus.result, v.exp);
        chk({v.name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        step();
        chk({v.name, "_done_width"}, {31'd0, bus.done}, 32'd0);
        chk({v.name, "_result_hold"}, bus.result, v.exp);
    endtask
    initial begin
        int lat;
        logic seen;
        vecs[0]  = '{2'b01, 32'd100, 32'd7, 32'd14, "divu_100_7"};
        vecs[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, "remu_100_7"};
        vecs[2]  = '{2'b00, 32'hffff_ff9c, 32'd7, 32'hffff_fff2, "div_m100_7"};
        vecs[3]  = '{2'b10, 32'hffff_ff9c, 32'd7, 32'hffff_fffe, "rem_m100_7"};
        vecs[4]  = '{2'b10, 32'd100, 32'hffff_fff9, 32'd2, "rem_100_m7"};
        vecs[5]  = '{2'b00, 32'd100, 32'hffff_fff9, 32'hffff_fff2, "div_100_m7"};
        vecs[6]  = '{2'b01, 32'd5, 32'd0, 32'hffff_ffff, "divu_5_0"};
        vecs[7]  = '{2'b11, 32'd5, 32'd0, 32'd5, "remu_5_0"};
        vecs[8]  = '{2'b00, 32'hffff_fffb, 32'd0, 32'hffff_ffff, "div_m5_0"};
        vecs[9]  = '{2'b10, 32'hffff_fffb, 32'd0, 32'hffff_fffb, "rem_m5_0"};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, "div_ovf"};
        vecs[11] = '{2'b10, 32'h8000_0000, 32'hffff_ffff, 32'd0, "rem_ovf"};
        vecs[12] = '{2'b01, 32'h8000_0000, 32'd3, 32'h2aaa_aaaa, "divu_2p31_3"};
        vecs[13] = '{2'b11, 32'h8000_0000, 32'd3, 32'd2, "remu_2p31_3"};
        vecs[14] = '{2'b00, 32'hffff_fff9, 32'hffff_fffe, 32'd3, "div_m7_m2"};
        vecs[15] = '{2'b10, 32'hffff_fff9, 32'hffff_fffe, 32'hffff_ffff, "rem_m7_m2"};
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) step();
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        step();
        foreach (vecs[i]) run_vec(vecs[i]);
        launch(2'b01, 32'd1000, 32'd10);
        repeat (9) step();
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.dividend = 32'd9;
        bus.divisor = 32'd3;
        step();
        bus.start = 1'b0;
        wait_done("ignored_start", 11, lat);
        chk("ignored_start_latency", lat, 34);
        chk("ignored_start_result", bus.result, 32'd100);
        launch(2'b01, 32'd9, 32'd3);
        chk("b2b_done_drop", {31'd0, bus.done}, 32'd0);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done("b2b", 1, lat);
        chk("b2b_latency", lat, 34);
        chk("b2b_result", bus.result, 32'd3);
        step();
        launch(2'b01, 32'hffff_ffff, 32'd1);
        repeat (14) step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("midrst_no_activity", {31'd0, seen}, 32'd0);
        run_vec('{2'b01, 32'd1000, 32'd10, 32'd100, "post_reset"});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
